inst_encode_writer: RTL

//  Inverse of the instruction decoder: accepts a 5-bit op code (same code set the decoder drives on LEDs) plus

---
 rtl/inst_encode_writer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/inst_encode_writer.sv
// Instruction assembler for loading IMEM: takes a decoder-style op code plus fields, builds the
// RV32I word and writes it at an auto-incrementing word address.
module inst_encode_writer #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_code,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [20:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [1:0]        state_dbg
);

  // Handshakes: a request transfers on a cycle where in_valid && in_ready && !clr; the
  // requester must hold in_valid and fields until then. An IMEM write transfers on a cycle
  // where mem_we && mem_ack; mem_addr/mem_wdata stay stable while mem_we waits for mem_ack.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2,
    S_FULL = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    F_R, F_I, F_L, F_S, F_B, F_J, F_BAD
  } fmt_t;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t      state, state_next;
  fmt_t        fmt;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] enc_word;
  logic        enc_bad;

  logic [4:0]  op_q, rd_q, rs1_q, rs2_q;
  logic [20:0] imm_q;

  logic            accept;
  logic            clear_now;
  logic            write_ok;
  logic [ADDR_W:0] count_inc;

  assign in_ready  = (state == S_IDLE);
  assign mem_we    = (state == S_WR);
  assign state_dbg = state;

  // clr wins over a simultaneous request in IDLE, so nothing is accepted that cycle
  assign accept    = (state == S_IDLE) && in_valid && !clr;
  assign clear_now = clr && ((state == S_IDLE) || (state == S_FULL));
  assign write_ok  = (state == S_WR) && mem_ack;
  assign count_inc = count + 1'b1;

  // Op code -> instruction format and function fields
  always_comb begin
    fmt = F_BAD;
    f7  = 7'b0000000;
    f3  = 3'd0;
    case (op_q)
      5'd1:  begin fmt = F_R; f3 = 3'd0; end
      5'd2:  begin fmt = F_R; f3 = 3'd0; f7 = 7'b0100000; end
      5'd3:  begin fmt = F_R; f3 = 3'd7; end
      5'd4:  begin fmt = F_R; f3 = 3'd6; end
      5'd5:  begin fmt = F_R; f3 = 3'd1; end
      5'd6:  begin fmt = F_R; f3 = 3'd5; end
      5'd7:  begin fmt = F_R; f3 = 3'd2; end
      5'd8:  begin fmt = F_I; f3 = 3'd0; end
      5'd9:  begin fmt = F_I; f3 = 3'd7; end
      5'd10: begin fmt = F_I; f3 = 3'd6; end
      5'd11: begin fmt = F_L; f3 = 3'd2; end
      5'd12: begin fmt = F_S; f3 = 3'd2; end
      5'd13: begin fmt = F_B; f3 = 3'd0; end
      5'd14: begin fmt = F_B; f3 = 3'd1; end
      5'd15: begin fmt = F_J; end
      default: fmt = F_BAD;
    endcase
  end

  // Field assembly; immediate bits above the format width are simply dropped
  always_comb begin
    enc_word = 32'd0;
    enc_bad  = 1'b0;
    case (fmt)
      F_R: enc_word = {f7, rs2_q, rs1_q, f3, rd_q, 7'b0110011};
      F_I: enc_word = {imm_q[11:0], rs1_q, f3, rd_q, 7'b0010011};
      F_L: enc_word = {imm_q[11:0], rs1_q, f3, rd_q, 7'b0000011};
      F_S: enc_word = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], 7'b0100011};
      F_B: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3, imm_q[4:1], imm_q[11], 7'b1100011};
        enc_bad  = imm_q[0];
      end
      F_J: begin
        enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
        // the decoder only recognises JAL when inst[14:12] == 0
        enc_bad  = imm_q[0] | (|imm_q[14:12]);
      end
      default: enc_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_ENC;
      S_ENC:  state_next = enc_bad ? S_IDLE : S_WR;
      S_WR:   if (mem_ack) state_next = (count_inc == DEPTH) ? S_FULL : S_IDLE;
      S_FULL: if (clr) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= 5'd0;
      rd_q      <= 5'd0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      imm_q     <= 21'd0;
      mem_wdata <= 32'd0;
      mem_addr  <= BASE;
      count     <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= write_ok;
      err   <= (state == S_ENC) && enc_bad;
      if (accept) begin
        op_q  <= op_code;
        rd_q  <= rd;
        rs1_q <= rs1;
        rs2_q <= rs2;
        imm_q <= imm;
      end
      if ((state == S_ENC) && !enc_bad) mem_wdata <= enc_word;
      if (clear_now) begin
        mem_addr <= BASE;
        count    <= '0;
        full     <= 1'b0;
      end else if (write_ok) begin
        mem_addr <= mem_addr + 1'b1;
        count    <= count_inc;
        full     <= (count_inc == DEPTH);
      end
    end
  end

endmodule
